// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   PC_STEP          byte distance between consecutive sequential fetches
//   DEF_XLEN/ILEN    widths of the default 32-bit configuration
//   fetch_entry_t    {pc, instr} pair as held in the prefetch buffer
//                    (default-width form; fetch_unit builds a local
//                    equivalent sized by its own parameters)
//   is_word_aligned  true when the two low address bits are zero
// No ports (package).
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_ILEN = 32;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory port, the redirect input and the decode
// handshake of the fetch stage.
//   imem_req/imem_addr    request to a synchronous memory (1-cycle latency)
//   imem_rdata            word for the request issued in the previous cycle
//   redirect_valid/_pc    single-cycle change of the fetch PC
//   instr_valid/ready     decode handshake, instr/instr_pc carry the head
// Modports:
//   master  - the fetch unit
//   slave   - memory, branch resolution and decode as seen from outside
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO with flush. The head entry comes straight from
// the storage registers, so head_valid/head_data never depend on pop.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             empties the FIFO (wins over push/pop)
//   push, push_data   write one entry at the tail
//   pop               remove the head entry (ignored when empty)
//   head_valid        FIFO not empty
//   head_data         head entry, all zeros when empty
//   count             number of stored entries
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? storage[rd_ptr] : '0;
    assign do_pop     = pop & head_valid;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the fetch PC, issues requests to a
// one-cycle-latency instruction memory, buffers returned words with their PC
// in a prefetch FIFO and presents them to decode over valid/ready. A redirect
// flushes everything in flight and restarts fetch at the new PC.
// Parameters: XLEN (PC width), ILEN (instruction width),
//             FIFO_DEPTH (power of two, >= 2), RESET_ADDR (word aligned).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   bus (master)       memory port, redirect input, decode handshake
//   fetch_misaligned   (FETCH_MISALIGN_CHECK_EN only) one-cycle pulse after
//                      a redirect to a non-word-aligned target
// Build option: FETCH_MISALIGN_CHECK_EN - misaligned redirect targets are
// rejected (fetch continues from the old PC) instead of being truncated.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic       clk,
    input  logic       reset,
    fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic       fetch_misaligned
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;
    logic            redirect_ok;
    logic [XLEN-1:0] redirect_target;
    entry_t          push_entry;
    entry_t          head_entry;
    logic            head_valid;
    logic [CW-1:0]   count;

    // Credit check: a request may only go out if its data is guaranteed a
    // FIFO slot, counting stored entries plus the outstanding request, minus
    // the entry decode is taking this cycle. This lets a pop free a credit
    // for a request in the same cycle.
    always_comb begin
        pop       = head_valid & bus.instr_ready;
        push      = inflight & ~bus.redirect_valid & ~reset;
        occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
        issue     = ~reset & ~bus.redirect_valid
                  & (occupancy < (CW+1)'(FIFO_DEPTH));
    end

    // Redirect target selection: with the check enabled a misaligned target
    // is refused; otherwise the low bits are simply dropped.
`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_ok     = is_word_aligned(bus.redirect_pc[1:0]);
    assign redirect_target = bus.redirect_pc;
`else
    assign redirect_ok     = 1'b1;
    assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

    // PC and in-flight tracking. Redirect outranks issue; a redirect never
    // coincides with an issue because issue is blocked during it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            if (redirect_ok) begin
                fetch_pc <= redirect_target;
            end
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Flag the refused redirect for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= bus.redirect_valid & ~redirect_ok;
        end
    end
`endif

    assign push_entry = '{pc: inflight_pc, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A queue-based reference model predicts
// the decode-side head, the memory request and the request address each
// cycle; directed phases exercise reset release, back-pressure, redirects and
// a wrap-around reset address (second instance), followed by random traffic.
// Honours FETCH_MISALIGN_CHECK_EN when defined.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RA1   = 32'h0000_0000;
    localparam logic [31:0] RA2   = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();
    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus2 ();

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis;
    logic mis2;
`endif

    fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .FIFO_DEPTH(DEPTH), .RESET_ADDR(RA1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (mis)
`endif
    );

    fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .FIFO_DEPTH(DEPTH), .RESET_ADDR(RA2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (mis2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memories: one-cycle read latency, junk when not requested.
    always_ff @(posedge clk) begin
        if (bus.imem_req === 1'b1) bus.imem_rdata <= mem_word(bus.imem_addr);
        else                       bus.imem_rdata <= $urandom;
        if (bus2.imem_req === 1'b1) bus2.imem_rdata <= mem_word(bus2.imem_addr);
        else                        bus2.imem_rdata <= $urandom;
    end

    // Reference model state.
    fetch_entry_t mq[$];
    logic [31:0]  mpend[$];
    logic [31:0]  mpc;
    logic         mmis;

    int          checks = 0;
    int          errors = 0;
    int          obs_req;
    int          mis_count;
    logic [31:0] pops[$];
    logic [31:0] pops2[$];
    logic [31:0] instr2_first;
    logic        last_valid;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance
    // the model to the state after the rising edge.
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_req;
        logic        pop;
        int          occ;
        @(negedge clk);
        reset              = rst;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        exp_valid = (mq.size() > 0);
        exp_pc    = exp_valid ? mq[0].pc : 32'h0;
        exp_instr = exp_valid ? mq[0].instr : 32'h0;
        pop       = exp_valid && rdy;
        occ       = mq.size() + mpend.size() - (pop ? 1 : 0);
        exp_req   = !rst && !rv && (occ < DEPTH);
        checkOutput("instr_valid", bus.instr_valid, exp_valid);
        checkOutput("instr_pc", bus.instr_pc, exp_pc);
        checkOutput("instr", bus.instr, exp_instr);
        checkOutput("imem_req", bus.imem_req, exp_req);
        checkOutput("imem_addr", bus.imem_addr, mpc);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("fetch_misaligned", mis, mmis);
        if (mis === 1'b1) mis_count++;
`endif
        if (bus.imem_req === 1'b1) obs_req++;
        if (bus.instr_valid === 1'b1 && rdy) pops.push_back(bus.instr_pc);
        last_valid = bus.instr_valid;
        if (bus2.instr_valid === 1'b1 && pops2.size() < 8) begin
            if (pops2.size() == 0) instr2_first = bus2.instr;
            pops2.push_back(bus2.instr_pc);
        end
        @(posedge clk);
        mmis = 1'b0;
        if (rst) begin
            mq.delete();
            mpend.delete();
            mpc = RA1;
        end else if (rv) begin
            mq.delete();
            mpend.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) mmis = 1'b1;
            else                   mpc  = rpc;
`else
            mpc = rpc & ~32'h3;
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (mpend.size() > 0) mq.push_back('{pc: mpend[0], instr: mem_word(mpend[0])});
            mpend.delete();
            if (exp_req) begin
                mpend.push_back(mpc);
                mpc = mpc + PC_STEP;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] first_pc;
        reset               = 1'b1;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.instr_ready    = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        mpc  = RA1;
        mmis = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, including the wrap-around instance.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("reset_addr2", bus2.imem_addr, RA2);
        checkOutput("reset_valid2", bus2.instr_valid, 1'b0);

        // Reset release with decode always ready.
        pops.delete();
        pops2.delete();
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stream_count", pops.size(), 4);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            checkOutput("stream_pc", pops[i], 32'(4 * i));
        checkOutput("wrap_count", pops2.size(), 4);
        if (pops2.size() >= 3) begin
            checkOutput("wrap_pc0", pops2[0], 32'hFFFF_FFF8);
            checkOutput("wrap_pc1", pops2[1], 32'hFFFF_FFFC);
            checkOutput("wrap_pc2", pops2[2], 32'h0000_0000);
            checkOutput("wrap_instr0", instr2_first, mem_word(32'hFFFF_FFF8));
        end

        // Back-pressure: exactly DEPTH requests, then drain in order.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        obs_req = 0;
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_requests", obs_req, DEPTH);
        pops.delete();
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("drain_count_min", pops.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < pops.size(); i++)
            checkOutput("drain_pc", pops[i], 32'(4 * i));

        // Redirect with one request in flight and two buffered entries.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        pops.delete();
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (last_valid === 1'b1) lat = k;
        end
        checkOutput("redirect_latency", lat, 3);
        first_pc = (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF;
        checkOutput("redirect_first_pc", first_pc, 32'h100);

        // Redirect and pop in the same cycle.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        pops.delete();
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        checkOutput("redir_pop_valid", last_valid, 1'b1);
        checkOutput("redir_pop_count", pops.size(), 1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_pop_empty", last_valid, 1'b0);

        // Misaligned redirect target.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h102, 1'b0);
        pops.delete();
        mis_count = 0;
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (last_valid === 1'b1) lat = k;
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("misalign_latency", lat, 3);
        first_pc = (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF;
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("misalign_resume_pc", first_pc, 32'h10);
        checkOutput("misalign_pulses", mis_count, 1);
`else
        checkOutput("misalign_resume_pc", first_pc, 32'h100);
`endif

        // Random traffic: back-pressure, redirects (any alignment), resets.
        for (int n = 0; n < 600; n++) begin
            logic rdy;
            logic rv;
            logic rst;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(rdy, rv, $urandom & 32'h0000_0FFF, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage replacing the free-running program counter. It holds the fetch PC and issues requests to a synchronous instruction memory with one-cycle read latency. Returned words are buffered with their PC in a small prefetch FIFO and handed to decode over a valid/ready handshake. It also accepts a redirect from branch/jump resolution that flushes all in-flight and buffered instructions.

## Interface
- `XLEN`, 32: PC/address width.
- `ILEN`, 32: instruction width.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥ 2.
- `RESET_ADDR`, 0: first fetch address; must be 4-byte aligned.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  XLEN  byte address of the request.
- `imem_rdata`  in  ILEN  data for the request issued in the previous cycle.
- `redirect_valid`  in  1  change fetch PC; single-cycle pulse.
- `redirect_pc`  in  XLEN  new fetch PC.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decode accepts head.
- `instr`  out  ILEN  head instruction; 0 when `instr_valid`=0.
- `instr_pc`  out  XLEN  head PC; 0 when `instr_valid`=0.
- `fetch_misaligned`  out  1  present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- State:
  - `fetch_pc` (XLEN)
  - `inflight` bit plus `inflight_pc`
  - FIFO of {pc, instr} entries with `count`.
- `pop` = `instr_valid & instr_ready`.
- Issue condition: `imem_req` = !reset & !redirect_valid & (count + inflight − pop < FIFO_DEPTH).
- `imem_addr` = `fetch_pc` at all times.
- On issue:
  - `inflight`<=1, `inflight_pc`<=`fetch_pc`.
  - `fetch_pc`<=`fetch_pc`+4, modulo 2^XLEN.
  - With no issue, `inflight`<=0.
- Writeback: if `inflight`=1 and no redirect this cycle, push {`inflight_pc`, `imem_rdata`}. The credit rule guarantees the FIFO is never full on push.
- Simultaneous push and pop: both take effect; `count` is unchanged.
- Redirect (highest priority):
  - `fetch_pc`<=`redirect_pc`, FIFO flushed (`count`<=0), `inflight`<=0.
  - The returning `imem_rdata` is discarded.
  - A pop completing in the redirect cycle is a valid transfer.
- Back-to-back redirects: the last one wins; no request is issued during any redirect cycle.

## Timing
- Reset values:
  - `fetch_pc`=RESET_ADDR, `imem_addr`=RESET_ADDR
  - `imem_req`=0, `inflight`=0, `count`=0
  - `instr_valid`=0, `instr`=0, `instr_pc`=0
  - `fetch_misaligned`=0
- Reset asserted mid-operation: all of the above restored on the next edge; in-flight data is dropped.
- First cycle after reset deasserts (C0): request RESET_ADDR.
- C1: data returns. C2: `instr_valid`=1.
- Redirect in cycle R: request `redirect_pc` at R+1; `instr_valid` with that PC at R+3. `instr_valid` is 0 at R+1 and R+2.
- Steady state: one instruction per cycle while `instr_ready`=1.
- `instr_ready`=0: FIFO fills, then `imem_req` drops. Fetch resumes the same cycle a pop frees a credit.
- `instr_valid` does not depend combinationally on `instr_ready`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 still flushes, but `fetch_pc` is unchanged.
  - `fetch_misaligned` pulses 1 for the cycle after the redirect.
  - Fetch resumes from the old `fetch_pc`.
- Undefined: the port is absent and `redirect_pc[1:0]` is forced to 0.

## Structure
- Package `fetch_pkg`:
  - `PC_STEP`=4
  - `fetch_entry_t` {pc, instr}
  - alignment-check function
- Sub-module `fetch_fifo`:
  - synchronous FIFO, parametrised `DEPTH`/entry width
  - push, pop, flush, count, registered head
- `fetch_unit` holds the PC, in-flight tracking and credit logic.

## Test plan
- Reset release, `instr_ready`=1, memory returns word = addr → `instr_pc` 0x0, 0x4, 0x8…
  - First `instr_valid` 2 cycles after the first request.
  - One instruction per cycle thereafter.
- `instr_ready`=0 for 10 cycles, DEPTH=4 → exactly 4 requests (0x0–0xC), then `imem_req`=0.
  - On release: 0x0–0xC popped in order, fetching resumes at 0x10, no gaps or duplicates.
- Redirect to 0x100 while a request is in flight and the FIFO holds 2 entries → stale entries never presented.
  - First instruction after the redirect has PC 0x100, 3 cycles after the redirect.
- Redirect and pop in the same cycle → popped entry counted once, FIFO empty next cycle.
- RESET_ADDR=0xFFFFFFF8 → PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102 → `fetch_misaligned` pulses once, FIFO flushed, fetch continues from the prior PC.
  - Without the macro: fetch resumes at 0x100.
